poly_eval_horner: RTL and testbench
===================================

// Module: poly_eval_horner
// PURPOSE
//  Parametrised polynomial evaluator y = c[D]*x^D + ... + c[1]*x + c[0], evaluated by Horner's rule.
//  Operands are entered serially on DataIn with a Go press/release handshake (switch + key front end).
//  One multiply-add step per clock on a shared MAC; the result is registered with a valid flag and a sticky overflow flag.
//  Successor to the fixed-width, fixed-polynomial lab datapath/control pair: width, degree and overflow mode are configurable.
// PARAMETERS
//  WIDTH     8  data, coefficient and result width in bits (unsigned), 2..32
//  DEGREE    3  polynomial degree D, 0..15; D+1 coefficients are stored
//  SATURATE  0  0: wrap modulo 2^WIDTH at every step; 1: clamp to 2^WIDTH-1 at every step
// PORTS
//  Clock        in   1      system clock, all state changes on the rising edge
//  Resetn       in   1      synchronous reset, active-low
//  Go           in   1      operand strobe; the level is sampled, press = high, release = low
//  DataIn       in   WIDTH  operand value, captured on a press
//  DataResult   out  WIDTH  registered polynomial value
//  ResultValid  out  1      DataResult holds a completed evaluation
//  Overflow     out  1      at least one step of the last evaluation exceeded WIDTH bits
//  Busy         out  1      high in S_INIT, S_STEP and S_DONE; Go is ignored there
// BEHAVIOUR
//  Reset (Resetn=0 at an edge):
//   - state = S_LOAD_X
//   - x, coef[], acc, idx, DataResult = 0
//   - ResultValid = 0, Overflow = 0
//   - Applies in any state, including mid-compute; any partial load is discarded.
//  Load order: x first, then c[D], c[D-1], ..., c[0]. Total D+2 presses.
//  FSM:
//   - S_LOAD_X: if Go, then x <= DataIn, ResultValid <= 0, Overflow <= 0, idx <= D, go to S_LOAD_X_WAIT.
//   - S_LOAD_X_WAIT: stay while Go; on release go to S_LOAD_C.
//   - S_LOAD_C: if Go, then coef[idx] <= DataIn and go to S_LOAD_C_WAIT.
//   - S_LOAD_C_WAIT: stay while Go. On release: if idx==0, go to S_INIT; else idx <= idx-1 and go to S_LOAD_C.
//   - S_INIT: acc <= coef[D], idx <= D-1. Next state is S_STEP, or S_DONE when D==0.
//   - S_STEP: acc <= mac(acc, x, coef[idx]). If idx==0, go to S_DONE; else idx <= idx-1.
//   - S_DONE: DataResult <= acc, ResultValid <= 1. Go to S_LOAD_X only once Go is low; otherwise hold.
//  Latency: S_DONE is entered D+1 cycles after the edge that samples the last release. ResultValid rises one edge later (D+2 edges in total).
//  ResultValid stays high, and DataResult is held, until the press that captures the next x.
//  Arithmetic (mac): full = acc*x + c, computed at 2*WIDTH+1 bits.
//   - ovf = (full >= 2^WIDTH).
//   - Result is full[WIDTH-1:0] when SATURATE==0, or all-ones when ovf && SATURATE==1.
//   - Overflow is sticky: Overflow <= Overflow | ovf on every S_STEP.
//  Go high while Busy is ignored. S_DONE's release gate prevents a press held through compute from being taken as the next x.
//  Unreachable state encodings return to S_LOAD_X on the next edge.
// STRUCTURE
//  Package poly_pkg:
//   - statetype enum {S_LOAD_X, S_LOAD_X_WAIT, S_LOAD_C, S_LOAD_C_WAIT, S_INIT, S_STEP, S_DONE}, logic [2:0]
//   - MAX_DEGREE = 15
//   - IDX_W = 4
//  Sub-module poly_mac #(WIDTH, SATURATE): combinational, inputs (a, b, c), outputs (y, ovf).
//  The top level holds the FSM, the coef register file (DEGREE+1 x WIDTH), x, acc, idx and the output registers.
//  A DEGREE outside 0..15 is a compile-time error via an elaboration $error.
// TESTING
//  1. WIDTH=8, D=3. x=2; c3..c0 = 1,2,3,4 -> DataResult=0x1A (26), ResultValid=1 on the 5th edge after the last release, Overflow=0.
//  2. WIDTH=8, D=3, SAT=0. x=10; c = 1,0,0,0 -> DataResult=0xE8 (1000 mod 256), Overflow=1. With SAT=1 -> 0xFF, Overflow=1.
//  3. D=0. x=9; c0=7 -> DataResult=7 on the 2nd edge after release; Busy high for exactly 2 cycles.
//  4. Assert Resetn=0 for 1 cycle during S_STEP of case 1:
//     - all outputs 0, state S_LOAD_X
//     - the following full load of case 1 gives 0x1A.
//  5. Back-to-back runs: case 1, then case 2.
//     - ResultValid stays 1 with 0x1A until x=10 is pressed, then drops.
//     - Overflow clears on that same press; the second result is correct.
//  6. Hold Go high from the last coefficient through compute:
//     - DataResult is valid, FSM stays in S_DONE, no x is captured
//     - after release, the next press loads x normally.

Source files
------------

// File: rtl/poly_eval_horner_pkg.sv
// Shared types and limits for the Horner polynomial evaluator.
package poly_pkg;

  typedef enum logic [2:0] {
    S_LOAD_X      = 3'd0,
    S_LOAD_X_WAIT = 3'd1,
    S_LOAD_C      = 3'd2,
    S_LOAD_C_WAIT = 3'd3,
    S_INIT        = 3'd4,
    S_STEP        = 3'd5,
    S_DONE        = 3'd6
  } statetype;

  localparam int MAX_DEGREE = 15;
  localparam int IDX_W      = 4;

endpackage

// File: rtl/poly_eval_horner_if.sv
// Operand strobe / result bus between the switch-and-key front end and the evaluator.
interface poly_eval_horner_if #(
  parameter int WIDTH = 8
);
  // Go is a level: high = key pressed, low = released. DataIn is taken on a press.
  logic             Go;
  logic [WIDTH-1:0] DataIn;
  logic [WIDTH-1:0] DataResult;
  logic             ResultValid;
  logic             Overflow;
  logic             Busy;

  modport master (
    output Go, DataIn,
    input  DataResult, ResultValid, Overflow, Busy
  );

  modport slave (
    input  Go, DataIn,
    output DataResult, ResultValid, Overflow, Busy
  );
endinterface

// File: rtl/poly_eval_horner_mac.sv
// Combinational Horner step: y = a*b + c with wrap or clamp, plus an overflow flag.
module poly_mac #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);
  localparam int FW = 2 * WIDTH + 1;

  logic [FW-1:0] full;

  // Full-width product plus addend can never exceed 2*WIDTH+1 bits.
  assign full = ({{(WIDTH + 1){1'b0}}, a} * {{(WIDTH + 1){1'b0}}, b})
              + {{(WIDTH + 1){1'b0}}, c};
  assign ovf  = |full[FW-1:WIDTH];
  assign y    = ((SATURATE != 0) && ovf) ? {WIDTH{1'b1}} : full[WIDTH-1:0];
endmodule

// File: rtl/poly_eval_horner.sv
// Serial-load polynomial evaluator: loads x then c[D]..c[0], then runs one Horner step per clock.
module poly_eval_horner
  import poly_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEGREE   = 3,
  parameter int SATURATE = 0
) (
  input  logic               Clock,
  input  logic               Resetn,
  poly_eval_horner_if.slave  bus,
  output statetype           dbg_state_o
);

  if (DEGREE < 0 || DEGREE > MAX_DEGREE) begin : g_bad_degree
    $error("poly_eval_horner: DEGREE %0d outside 0..%0d", DEGREE, MAX_DEGREE);
  end
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("poly_eval_horner: WIDTH %0d outside 2..32", WIDTH);
  end

  localparam logic [IDX_W-1:0] D_IDX = IDX_W'(DEGREE);

  statetype         state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] acc_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] result_q;
  logic             valid_q;
  logic             ovf_q;
  logic [WIDTH-1:0] coef_q [DEGREE+1];

  logic [WIDTH-1:0] coef_sel;
  logic [WIDTH-1:0] acc_d;
  logic             step_ovf;

  // Read mux over the register file keyed on the 4-bit index.
  always_comb begin
    coef_sel = '0;
    for (int i = 0; i <= DEGREE; i++) begin
      if (idx_q == IDX_W'(i)) coef_sel = coef_q[i];
    end
  end

  poly_mac #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_mac (
    .a   (acc_q),
    .b   (x_q),
    .c   (coef_sel),
    .y   (acc_d),
    .ovf (step_ovf)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= S_LOAD_X;
      x_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i <= DEGREE; i++) coef_q[i] <= '0;
    end else begin
      case (state_q)
        S_LOAD_X: begin
          if (bus.Go) begin
            x_q     <= bus.DataIn;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= D_IDX;
            state_q <= S_LOAD_X_WAIT;
          end
        end
        S_LOAD_X_WAIT: if (!bus.Go) state_q <= S_LOAD_C;
        S_LOAD_C: begin
          if (bus.Go) begin
            for (int i = 0; i <= DEGREE; i++) begin
              if (idx_q == IDX_W'(i)) coef_q[i] <= bus.DataIn;
            end
            state_q <= S_LOAD_C_WAIT;
          end
        end
        S_LOAD_C_WAIT: begin
          if (!bus.Go) begin
            if (idx_q == '0) begin
              state_q <= S_INIT;
            end else begin
              idx_q   <= idx_q - 1'b1;
              state_q <= S_LOAD_C;
            end
          end
        end
        S_INIT: begin
          acc_q <= coef_q[DEGREE];
          if (DEGREE == 0) begin
            state_q <= S_DONE;
          end else begin
            idx_q   <= D_IDX - 1'b1;
            state_q <= S_STEP;
          end
        end
        S_STEP: begin
          acc_q <= acc_d;
          ovf_q <= ovf_q | step_ovf;
          if (idx_q == '0) state_q <= S_DONE;
          else             idx_q   <= idx_q - 1'b1;
        end
        S_DONE: begin
          result_q <= acc_q;
          valid_q  <= 1'b1;
          // A key still held from compute must be released before the next x.
          if (!bus.Go) state_q <= S_LOAD_X;
        end
        default: state_q <= S_LOAD_X;
      endcase
    end
  end

  assign bus.DataResult  = result_q;
  assign bus.ResultValid = valid_q;
  assign bus.Overflow    = ovf_q;
  assign bus.Busy        = (state_q == S_INIT) || (state_q == S_STEP) || (state_q == S_DONE);
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_poly_eval_horner.sv
// Directed bench: wrap (D=3), saturate (D=3) and degree-0 evaluators with hand-computed results.
module tb_poly_eval_horner;
  import poly_pkg::*;

  logic       clk;
  logic       rstn;
  logic       go_a, go_z;
  logic [7:0] din_a, din_z;
  statetype   st_a, st_s, st_z;

  int n_checks;
  int n_errors;
  logic [7:0] exp_q[$];

  poly_eval_horner_if #(.WIDTH(8)) if_a ();
  poly_eval_horner_if #(.WIDTH(8)) if_s ();
  poly_eval_horner_if #(.WIDTH(8)) if_z ();

  assign if_a.Go = go_a;  assign if_a.DataIn = din_a;
  assign if_s.Go = go_a;  assign if_s.DataIn = din_a;
  assign if_z.Go = go_z;  assign if_z.DataIn = din_z;

  poly_eval_horner #(.WIDTH(8), .DEGREE(3), .SATURATE(0)) u_wrap (
    .Clock(clk), .Resetn(rstn), .bus(if_a), .dbg_state_o(st_a));
  poly_eval_horner #(.WIDTH(8), .DEGREE(3), .SATURATE(1)) u_sat (
    .Clock(clk), .Resetn(rstn), .bus(if_s), .dbg_state_o(st_s));
  poly_eval_horner #(.WIDTH(8), .DEGREE(0), .SATURATE(0)) u_d0 (
    .Clock(clk), .Resetn(rstn), .bus(if_z), .dbg_state_o(st_z));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one press/release of the key; the release is sampled at the following rising edge
  task automatic press(input bit z, input logic [7:0] v);
    @(negedge clk);
    if (z) begin go_z = 1'b1; din_z = v; end
    else   begin go_a = 1'b1; din_a = v; end
    @(negedge clk);
    if (z) go_z = 1'b0;
    else   go_a = 1'b0;
  endtask

  task automatic press_coefs(input logic [7:0] c3, input logic [7:0] c2,
                             input logic [7:0] c1, input logic [7:0] c0);
    press(1'b0, c3);
    press(1'b0, c2);
    press(1'b0, c1);
    press(1'b0, c0);
  endtask

  // edge that samples the last release, then D+1 edges to S_DONE, one more to valid
  task automatic wait_result(input string tag);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 check({tag, "_valid_early"}, 32'(if_a.ResultValid), 32'd0);
    @(posedge clk);
    #1 check({tag, "_valid"}, 32'(if_a.ResultValid), 32'd1);
    check({tag, "_result"}, 32'(if_a.DataResult), 32'(exp_q.pop_front()));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    go_a = 1'b0; go_z = 1'b0; din_a = '0; din_z = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", 32'(if_a.DataResult), 32'd0);
    check("rst_valid", 32'(if_a.ResultValid), 32'd0);
    check("rst_ovf", 32'(if_a.Overflow), 32'd0);
    check("rst_busy", 32'(if_a.Busy), 32'd0);
    check("rst_state", 32'(st_a), 32'(S_LOAD_X));
    check("rst_d0_valid", 32'(if_z.ResultValid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // case 1: x=2, 1,2,3,4 -> 26
    press(1'b0, 8'd2);
    press_coefs(8'd1, 8'd2, 8'd3, 8'd4);
    exp_q.push_back(8'h1A);
    wait_result("c1");
    check("c1_ovf", 32'(if_a.Overflow), 32'd0);
    check("c1_sat_result", 32'(if_s.DataResult), 32'h1A);
    repeat (3) @(posedge clk);
    #1 check("c1_hold_valid", 32'(if_a.ResultValid), 32'd1);

    // back-to-back case 2: x=10, 1,0,0,0 -> 1000
    press(1'b0, 8'd10);
    check("c2_xpress_valid", 32'(if_a.ResultValid), 32'd0);
    check("c2_xpress_result", 32'(if_a.DataResult), 32'h1A);
    press_coefs(8'd1, 8'd0, 8'd0, 8'd0);
    exp_q.push_back(8'hE8);
    wait_result("c2");
    check("c2_ovf", 32'(if_a.Overflow), 32'd1);
    check("c2_sat_result", 32'(if_s.DataResult), 32'hFF);
    check("c2_sat_ovf", 32'(if_s.Overflow), 32'd1);

    // case 1 again: the x press must clear the sticky overflow
    press(1'b0, 8'd2);
    check("c1b_xpress_ovf", 32'(if_a.Overflow), 32'd0);
    check("c1b_xpress_valid", 32'(if_a.ResultValid), 32'd0);
    press_coefs(8'd1, 8'd2, 8'd3, 8'd4);
    exp_q.push_back(8'h1A);
    wait_result("c1b");
    check("c1b_ovf", 32'(if_a.Overflow), 32'd0);

    // case 3: degree 0, x=9, c0=7
    press(1'b1, 8'd9);
    press(1'b1, 8'd7);
    @(posedge clk);
    #1 check("d0_busy1", 32'(if_z.Busy), 32'd1);
    @(posedge clk);
    #1 check("d0_busy2", 32'(if_z.Busy), 32'd1);
    check("d0_valid_early", 32'(if_z.ResultValid), 32'd0);
    @(posedge clk);
    #1 check("d0_busy3", 32'(if_z.Busy), 32'd0);
    check("d0_valid", 32'(if_z.ResultValid), 32'd1);
    check("d0_result", 32'(if_z.DataResult), 32'd7);

    // case 4: reset during S_STEP
    press(1'b0, 8'd2);
    press_coefs(8'd1, 8'd2, 8'd3, 8'd4);
    repeat (3) @(posedge clk);
    #1 check("r4_in_step", 32'(st_a), 32'(S_STEP));
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("r4_state", 32'(st_a), 32'(S_LOAD_X));
    check("r4_result", 32'(if_a.DataResult), 32'd0);
    check("r4_valid", 32'(if_a.ResultValid), 32'd0);
    check("r4_ovf", 32'(if_a.Overflow), 32'd0);
    check("r4_busy", 32'(if_a.Busy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    press(1'b0, 8'd2);
    press_coefs(8'd1, 8'd2, 8'd3, 8'd4);
    exp_q.push_back(8'h1A);
    wait_result("r4_reload");

    // case 6: key pressed right after the last release and held through compute
    press(1'b0, 8'd2);
    press_coefs(8'd1, 8'd2, 8'd3, 8'd4);
    @(posedge clk);
    @(negedge clk);
    go_a = 1'b1;
    din_a = 8'h55;
    repeat (10) @(posedge clk);
    #1;
    check("h6_state", 32'(st_a), 32'(S_DONE));
    check("h6_busy", 32'(if_a.Busy), 32'd1);
    check("h6_valid", 32'(if_a.ResultValid), 32'd1);
    check("h6_result", 32'(if_a.DataResult), 32'h1A);
    @(negedge clk);
    go_a = 1'b0;
    @(posedge clk);
    #1 check("h6_release_state", 32'(st_a), 32'(S_LOAD_X));
    check("h6_release_valid", 32'(if_a.ResultValid), 32'd1);
    press(1'b0, 8'd10);
    press_coefs(8'd1, 8'd0, 8'd0, 8'd0);
    exp_q.push_back(8'hE8);
    wait_result("h6_next");
    check("h6_next_ovf", 32'(if_a.Overflow), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
